// File: rtl/xgmii_link_monitor_pkg.sv
// Shared XGMII character constants, fault codes, FSM encoding and column decoder
// for the 10GBASE-R receive link monitor.
package xgmii_link_monitor_pkg;

    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_ERROR = 8'hFE;
    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_SEQ   = 8'h9C;

    localparam logic [7:0] FAULT_LOCAL  = 8'h01;
    localparam logic [7:0] FAULT_REMOTE = 8'h02;

    localparam logic [1:0] ST_OK    = 2'd0;
    localparam logic [1:0] ST_HUNT  = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    localparam logic FT_LOCAL  = 1'b0;
    localparam logic FT_REMOTE = 1'b1;

    localparam int unsigned SEQ_THRESH = 4;

    typedef struct packed {
        logic hit;
        logic remote;
    } col_seq_t;

    // Recognise a link-fault sequence ordered set in one four-lane column.
    function automatic col_seq_t decode_column(input logic [31:0] d, input logic [3:0] c);
        col_seq_t r;
        logic     hdr_ok;
        hdr_ok   = (c == 4'b0001) && (d[7:0] == XGMII_SEQ) &&
                   (d[15:8] == 8'h00) && (d[23:16] == 8'h00);
        r.hit    = hdr_ok && ((d[31:24] == FAULT_LOCAL) || (d[31:24] == FAULT_REMOTE));
        r.remote = (d[31:24] == FAULT_REMOTE);
        return r;
    endfunction

endpackage

// File: rtl/xgmii_fault_fsm.sv
// Link-fault sequence tracker: counts fault ordered sets of one type and
// declares/clears local or remote fault over a column window.
module xgmii_fault_fsm
    import xgmii_link_monitor_pkg::*;
#(
    parameter int unsigned FAULT_COLS = 128
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       block_lock,
    input  logic       hit_a,
    input  logic       remote_a,
    input  logic       hit_b,
    input  logic       remote_b,
    output logic       local_fault,
    output logic       remote_fault,
    output logic [1:0] state_nxt_c
);

    localparam int unsigned COL_W = $clog2(FAULT_COLS + 1);
    localparam logic [COL_W-1:0] COL_LIMIT = COL_W'(FAULT_COLS);

    logic [1:0]       state;
    logic             ftype;
    logic [2:0]       seq_cnt;
    logic [COL_W-1:0] col_cnt;

    logic             ftype_nxt;
    logic [2:0]       seq_nxt;
    logic [COL_W-1:0] col_nxt;
    logic             local_nxt;
    logic             remote_nxt;

    logic             any_hit;
    logic             cyc_remote;
    logic [1:0]       n_hits;
    logic [2:0]       seq_sum;
    logic [COL_W-1:0] col_inc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_OK;
            ftype        <= FT_LOCAL;
            seq_cnt      <= '0;
            col_cnt      <= '0;
            local_fault  <= 1'b0;
            remote_fault <= 1'b0;
        end else begin
            state        <= state_nxt_c;
            ftype        <= ftype_nxt;
            seq_cnt      <= seq_nxt;
            col_cnt      <= col_nxt;
            local_fault  <= local_nxt;
            remote_fault <= remote_nxt;
        end
    end

    // Column B decides the cycle's type when both columns carry sequences.
    always_comb begin
        any_hit    = hit_a | hit_b;
        cyc_remote = hit_b ? remote_b : remote_a;
        n_hits     = {1'b0, hit_a && (remote_a == cyc_remote)} +
                     {1'b0, hit_b && (remote_b == cyc_remote)};
        seq_sum    = seq_cnt + 3'(n_hits);
        col_inc    = col_cnt + COL_W'(2);

        state_nxt_c = state;
        ftype_nxt   = ftype;
        seq_nxt     = seq_cnt;
        col_nxt     = col_cnt;

        if (!block_lock) begin
            state_nxt_c = ST_OK;
            ftype_nxt   = FT_LOCAL;
            seq_nxt     = '0;
            col_nxt     = '0;
        end else begin
            case (state)
                ST_OK: begin
                    if (any_hit) begin
                        state_nxt_c = ST_HUNT;
                        ftype_nxt   = cyc_remote;
                        seq_nxt     = 3'(n_hits);
                        col_nxt     = '0;
                    end
                end
                ST_HUNT, ST_FAULT: begin
                    if (any_hit && (cyc_remote == ftype)) begin
                        col_nxt = '0;
                        if (state == ST_HUNT) begin
                            if (seq_sum >= 3'(SEQ_THRESH)) begin
                                state_nxt_c = ST_FAULT;
                                seq_nxt     = 3'(SEQ_THRESH);
                            end else begin
                                seq_nxt = seq_sum;
                            end
                        end
                    end else if (any_hit) begin
                        state_nxt_c = ST_HUNT;
                        ftype_nxt   = cyc_remote;
                        seq_nxt     = 3'(n_hits);
                        col_nxt     = '0;
                    end else if (col_inc >= COL_LIMIT) begin
                        state_nxt_c = ST_OK;
                        ftype_nxt   = FT_LOCAL;
                        seq_nxt     = '0;
                        col_nxt     = '0;
                    end else begin
                        col_nxt = col_inc;
                    end
                end
                default: begin
                    state_nxt_c = ST_OK;
                    ftype_nxt   = FT_LOCAL;
                    seq_nxt     = '0;
                    col_nxt     = '0;
                end
            endcase
        end

        local_nxt  = (state_nxt_c == ST_FAULT) && (ftype_nxt == FT_LOCAL);
        remote_nxt = (state_nxt_c == ST_FAULT) && (ftype_nxt == FT_REMOTE);
    end

endmodule

// File: rtl/xgmii_link_monitor.sv
// Receive-side XGMII link monitor: fault tracking, link-up debounce and
// frame/error statistics for one 10GBASE-R lane.
module xgmii_link_monitor
    import xgmii_link_monitor_pkg::*;
#(
    parameter int unsigned LINK_UP_CYCLES = 1024,
    parameter int unsigned FAULT_COLS     = 128,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [63:0]          xgmii_rxd,
    input  logic [7:0]           xgmii_rxc,
    input  logic                 rx_block_lock,
    input  logic                 stat_clear,
    output logic                 link_up,
    output logic                 local_fault,
    output logic                 remote_fault,
    output logic [CNT_WIDTH-1:0] frame_count,
    output logic [CNT_WIDTH-1:0] error_count
);

    localparam int unsigned DB_W = $clog2(LINK_UP_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(LINK_UP_CYCLES - 1);

    col_seq_t         col_a;
    col_seq_t         col_b;
    logic [1:0]       state_nxt;
    logic             clean;
    logic [DB_W-1:0]  db_cnt;
    logic             start_0;
    logic             start_4;
    logic [1:0]       start_inc;
    logic             err_hit;

    always_comb begin
        col_a = decode_column(xgmii_rxd[31:0],  xgmii_rxc[3:0]);
        col_b = decode_column(xgmii_rxd[63:32], xgmii_rxc[7:4]);
    end

    xgmii_fault_fsm #(
        .FAULT_COLS (FAULT_COLS)
    ) u_fault_fsm (
        .clk          (clk),
        .rst_n        (rst_n),
        .block_lock   (rx_block_lock),
        .hit_a        (col_a.hit),
        .remote_a     (col_a.remote),
        .hit_b        (col_b.hit),
        .remote_b     (col_b.remote),
        .local_fault  (local_fault),
        .remote_fault (remote_fault),
        .state_nxt_c  (state_nxt)
    );

    // Judge cleanliness on the FSM's next state so link_up drops one cycle after the bad input.
    assign clean = rx_block_lock && (state_nxt == ST_OK);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            db_cnt  <= '0;
            link_up <= 1'b0;
        end else if (!clean) begin
            db_cnt  <= '0;
            link_up <= 1'b0;
        end else if (db_cnt == DB_LAST) begin
            link_up <= 1'b1;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    always_comb begin
        start_0   = xgmii_rxc[0] && (xgmii_rxd[7:0]   == XGMII_START);
        start_4   = xgmii_rxc[4] && (xgmii_rxd[39:32] == XGMII_START);
        start_inc = {1'b0, start_0} + {1'b0, start_4};
        err_hit   = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (xgmii_rxc[k] && (xgmii_rxd[8*k +: 8] == XGMII_ERROR)) begin
                err_hit = 1'b1;
            end
        end
    end

    // Statistics wrap naturally; a clear drops that cycle's events.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_count <= '0;
            error_count <= '0;
        end else if (stat_clear) begin
            frame_count <= '0;
            error_count <= '0;
        end else begin
            frame_count <= frame_count + CNT_WIDTH'(start_inc);
            error_count <= error_count + CNT_WIDTH'(err_hit);
        end
    end

endmodule
